// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART receiver: receiver
//                state encoding and the baud divider calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        BRK_WAIT = 3'd4
    } state_t;

    // Clock cycles per oversample tick (integer division, truncating).
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_receiver_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Free-running divider producing a one-clk oversample tick
//                every DIV clocks; restart re-aligns the phase to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,     // synchronous, active-low
    input  logic restart,
    output logic tick
);

    localparam int                C_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [C_W-1:0]    C_LAST = C_W'(DIV - 1);

    logic [C_W-1:0] r_cnt;

    // Divider counter: 0..DIV-1, forced back to 0 on restart.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == C_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == C_LAST);

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receiver with 3-sample majority vote, framing
//                error detection and break absorption. Good bytes are
//                presented with a one-clk ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,          // synchronous, active-low
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_ready,
    output logic       frame_error,
    output logic       busy
);

    localparam int              C_DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int              C_TW    = $clog2(OVERSAMPLE);
    localparam int              C_MID   = OVERSAMPLE / 2;
    localparam logic [C_TW-1:0] C_T_MM1 = C_TW'(C_MID - 1);
    localparam logic [C_TW-1:0] C_T_MID = C_TW'(C_MID);
    localparam logic [C_TW-1:0] C_T_MP1 = C_TW'(C_MID + 1);
    localparam logic [C_TW-1:0] C_T_END = C_TW'(OVERSAMPLE - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_sync;
    logic            w_rx_s;
    logic            w_tick;
    logic [C_TW-1:0] r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic            r_samp0;
    logic            r_samp1;
    logic            w_vote;
    logic            w_at_dec;
    logic            w_at_end;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx_data;
    logic            r_ready;
    logic            r_ferr;

    // FSM control strobes
    logic            w_restart;
    logic            w_clr_tick;
    logic            w_clr_bit;
    logic            w_shift;
    logic            w_bit_inc;
    logic            w_deliver;
    logic            w_set_ferr;

    // Two-flop synchronizer, preset high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rx_s = r_sync[1];

    baud_tick_gen #(
        .DIV     (C_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Decision points inside a bit and the majority of the three mid-bit samples.
    assign w_at_dec = w_tick && (r_tick_cnt == C_T_MP1);
    assign w_at_end = w_tick && (r_tick_cnt == C_T_END);
    assign w_vote   = (r_samp0 & r_samp1) | (r_samp0 & w_rx_s) | (r_samp1 & w_rx_s);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_clr_tick  = 1'b0;
        w_clr_bit   = 1'b0;
        w_shift     = 1'b0;
        w_bit_inc   = 1'b0;
        w_deliver   = 1'b0;
        w_set_ferr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_restart   = 1'b1;
                    w_clr_tick  = 1'b1;
                    w_clr_bit   = 1'b1;
                end
            end
            START: begin
                if (w_at_dec && w_vote) begin
                    w_state_nxt = IDLE;     // false start: line went back high
                end else if (w_at_end) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_shift = w_at_dec;
                if (w_at_end) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit of resync margin.
                if (w_at_dec) begin
                    if (w_vote) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_set_ferr  = 1'b1;
                        w_clr_tick  = 1'b1;
                        w_state_nxt = BRK_WAIT;
                    end
                end
            end
            BRK_WAIT: begin
                // tick_cnt counts consecutive high ticks; any low restarts it.
                if (w_tick) begin
                    if (!w_rx_s) begin
                        w_clr_tick = 1'b1;
                    end else if (r_tick_cnt == C_T_END) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Tick and bit counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if (w_clr_tick) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= (r_tick_cnt == C_T_END) ? '0 : r_tick_cnt + 1'b1;
            end
            if (w_clr_bit) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Mid-bit samples and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_samp0 <= 1'b1;
            r_samp1 <= 1'b1;
            r_shift <= '0;
        end else begin
            if (w_tick && (r_tick_cnt == C_T_MM1)) begin
                r_samp0 <= w_rx_s;
            end
            if (w_tick && (r_tick_cnt == C_T_MID)) begin
                r_samp1 <= w_rx_s;
            end
            if (w_shift) begin
                r_shift <= {w_vote, r_shift[7:1]};
            end
        end
    end

    // Output byte, ready pulse and sticky framing error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_data <= 8'h00;
            r_ready   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_ready <= w_deliver;
            if (w_deliver) begin
                r_rx_data <= r_shift;
                r_ferr    <= 1'b0;
            end else if (w_set_ferr) begin
                r_ferr    <= 1'b1;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_data_ready = r_ready;
    assign frame_error   = r_ferr;
    assign busy          = (r_state != IDLE);

endmodule : uart_receiver
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Self-checking bench for uart_receiver. Directed scenarios
//                plus random frames; expected bytes go to a scoreboard queue
//                that a monitor drains on each ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OVS      = 16;
    localparam int BIT      = CLK_FREQ / BAUD;              // 160 clk per bit
    localparam int TICK     = CLK_FREQ / (BAUD * OVS);      // 10 clk per tick
    // Pin start edge to ready: 2 synchronizer clk + 1 detect clk, nine whole
    // bits (start + 8 data), then stop-bit vote completes on tick M+1, i.e.
    // (M+2) divider periods into the stop bit, plus the registering clk.
    localparam int LAT      = 3 + 9 * BIT + (OVS / 2 + 2) * TICK;
    localparam int LAT_TOL  = 5;

    typedef struct {
        logic [7:0] data;
        longint     due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       frame_error;
    logic       busy;

    exp_t       sb[$];
    longint     cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_data = 8'h00;
    logic       prev_ready = 1'b0;

    uart_receiver #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD          (BAUD),
        .OVERSAMPLE    (OVS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every ready pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rx_data_ready) begin
            exp_t e;
            check("ready_width", {31'd0, prev_ready}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got rx_data %0h with no frame expected (cycle %0d)", rx_data, cyc);
            end else begin
                longint lat;
                e = sb.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                check("frame_error_on_pulse", {31'd0, frame_error}, 32'd0);
                lat = cyc - e.due + LAT;
                n_checks++;
                if ((cyc < e.due - LAT_TOL) || (cyc > e.due + LAT_TOL)) begin
                    n_fail++;
                    $display("FAIL ready_latency: got %0d clk expected %0d +/- %0d", lat, LAT, LAT_TOL);
                end
            end
        end
        prev_ready = rx_data_ready;
    end

    // Drives one 8N1 frame. glitch_bit >= 0 pulls the line low for 10 clk
    // around the middle of that data bit; abort_bit >= 0 pulses reset half
    // way into that data bit and then idles the line.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input int glitch_bit, input int abort_bit);
        logic [9:0] fr;
        exp_t       e;
        fr = {stop_v, d, 1'b0};
        if (stop_v && abort_bit < 0) begin
            e.data = d;
            e.due  = cyc + LAT;
            sb.push_back(e);
            exp_data = d;
        end
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < BIT; j++) begin
                if (abort_bit >= 0 && i == abort_bit + 1 && j == BIT / 2) begin
                    rx    = 1'b1;
                    reset = 1'b0;
                    step(1);
                    reset = 1'b1;
                    exp_data = 8'h00;
                    return;
                end
                rx = fr[i];
                if (glitch_bit >= 0 && i == glitch_bit + 1 && j >= 85 && j < 95) begin
                    rx = 1'b0;
                end
                step(1);
            end
        end
        rx = 1'b1;
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        rx    = 1'b1;
        reset = 1'b0;
        step(5);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_ready", {31'd0, rx_data_ready}, 32'd0);
        check("rst_frame_error", {31'd0, frame_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        step(20);

        // Single good frame
        send_frame(8'hA3, 1'b1, -1, -1);
        step(200);
        check("a3_busy", {31'd0, busy}, 32'd0);
        check("a3_data", {24'd0, rx_data}, 32'h0A3);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        step(200);
        check("b2b_data", {24'd0, rx_data}, 32'h0FF);

        // 40-clk low pulse: false start
        rx = 1'b0;
        step(40);
        rx = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 130; k++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        check("false_start_busy_clear", {31'd0, ok}, 32'd1);
        step(200);
        check("false_start_data", {24'd0, rx_data}, {24'd0, exp_data});

        // Framing error, then a good frame clears it
        send_frame(8'h5A, 1'b0, -1, -1);
        step(300);
        check("ferr_set", {31'd0, frame_error}, 32'd1);
        check("ferr_data_kept", {24'd0, rx_data}, {24'd0, exp_data});
        send_frame(8'h11, 1'b1, -1, -1);
        step(200);
        check("ferr_cleared", {31'd0, frame_error}, 32'd0);
        check("after_ferr_data", {24'd0, rx_data}, 32'h011);

        // Mid-bit glitch outvoted
        send_frame(8'hFF, 1'b1, 3, -1);
        step(200);
        check("glitch_data", {24'd0, rx_data}, 32'h0FF);

        // Reset during data bit 4
        send_frame(8'h77, 1'b1, -1, 4);
        step(5);
        check("abort_rx_data", {24'd0, rx_data}, 32'd0);
        check("abort_ready", {31'd0, rx_data_ready}, 32'd0);
        check("abort_frame_error", {31'd0, frame_error}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        step(200);
        send_frame(8'h3C, 1'b1, -1, -1);
        step(200);
        check("post_abort_data", {24'd0, rx_data}, 32'h03C);

        // Random frames: random byte, occasional bad stop bit, glitches, gaps
        for (int n = 0; n < 8; n++) begin
            logic [7:0] d;
            logic       stop_v;
            int         gl;
            d      = 8'($urandom);
            stop_v = ($urandom_range(0, 3) != 0);
            gl     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            send_frame(d, stop_v, gl, -1);
            if (stop_v) begin
                check("rand_ferr_clear", {31'd0, frame_error}, 32'd0);
                check("rand_data", {24'd0, rx_data}, {24'd0, exp_data});
                step(int'($urandom_range(0, 300)));
            end else begin
                step(200 + int'($urandom_range(0, 200)));
                check("rand_ferr_set", {31'd0, frame_error}, 32'd1);
                check("rand_data_kept", {24'd0, rx_data}, {24'd0, exp_data});
            end
        end

        step(500);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_receiver
`default_nettype wire
